// File: rtl/stack_cmd_sequencer.sv
// Request sequencer in front of the 5-entry, 4-bit stack; checks legality and issues one command at a time.
// Latency: legal push/pop/get responds 2 edges after accept, nop/error 1 edge after accept.
// Backpressure: REQ_READY only in IDLE; the response is held until RSP_READY, and no new request is taken meanwhile.
module stack_cmd_sequencer #(
    parameter int DEPTH = 5,
    parameter int DW    = 4,
    parameter int IW    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [1:0]    i_req_op,
    input  logic [IW-1:0] i_req_index,
    input  logic [DW-1:0] i_req_data,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_err,
    output logic [1:0]    o_command,
    output logic [IW-1:0] o_index,
    output logic [DW-1:0] o_i_data,
    input  logic [DW-1:0] i_o_data,
    output logic [2:0]    o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_GET  = 2'b11;

    localparam logic [2:0] COUNT_FULL = 3'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [2:0]    r_count;
    logic [1:0]    r_command;
    logic [IW-1:0] r_index;
    logic [DW-1:0] r_i_data;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_err;

    logic          w_accept;
    logic          w_legal;
    logic          w_stack_op;

    assign w_accept   = i_req_valid && (r_state == S_IDLE);
    assign w_stack_op = (i_req_op != OP_NOP);

    // Legality of the offered request against the current occupancy
    always_comb begin
        w_legal = 1'b1;
        case (i_req_op)
            OP_PUSH: w_legal = (r_count != COUNT_FULL);
            OP_POP:  w_legal = (r_count != 3'd0);
            OP_GET:  w_legal = (i_req_index < r_count);
            default: w_legal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: nops and rejected requests skip ISSUE entirely
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_legal && w_stack_op) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: w_next_state = S_RESP;
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        o_req_ready = (r_state == S_IDLE);
        o_rsp_valid = (r_state == S_RESP);
    end

    // Datapath: stack command registers live only for the ISSUE cycle; occupancy and
    // the read result update on the edge leaving ISSUE. r_command doubles as the latched op.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= 3'd0;
            r_command  <= OP_NOP;
            r_index    <= '0;
            r_i_data   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= ~w_legal;
                        if (w_legal && w_stack_op) begin
                            r_command <= i_req_op;
                            r_index   <= (i_req_op == OP_GET)  ? i_req_index : '0;
                            r_i_data  <= (i_req_op == OP_PUSH) ? i_req_data  : '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_command <= OP_NOP;
                    r_index   <= '0;
                    r_i_data  <= '0;
                    if (r_command == OP_PUSH) begin
                        r_count <= r_count + 3'd1;
                    end else if (r_command == OP_POP) begin
                        r_count <= r_count - 3'd1;
                    end
                    if ((r_command == OP_POP) || (r_command == OP_GET)) begin
                        r_rsp_data <= i_o_data;
                    end
                end
                default: begin
                    r_command <= OP_NOP;
                end
            endcase
        end
    end

    assign o_command  = r_command;
    assign o_index    = r_index;
    assign o_i_data   = r_i_data;
    assign o_rsp_data = r_rsp_data;
    assign o_rsp_err  = r_rsp_err;
    assign o_count    = r_count;
    assign o_full     = (r_count == COUNT_FULL);
    assign o_empty    = (r_count == 3'd0);

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed bench for stack_cmd_sequencer with a behavioural model of the downstream stack.
// Each request pushes its expected response to a scoreboard queue; responses are popped and compared.
module tb_stack_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_index;
    logic [3:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic [1:0] command;
    logic [2:0] index;
    logic [3:0] i_data;
    logic [3:0] o_data;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    // scoreboard entry: {err, data}
    logic [4:0] exp_q[$];

    stack_cmd_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_index (req_index),
        .i_req_data  (req_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_command   (command),
        .o_index     (index),
        .o_i_data    (i_data),
        .i_o_data    (o_data),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: mem[0] is bottom, mem[sp-1] is top
    logic [3:0] mem [0:7];
    int         sp;
    int         sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= 0;
        end else if (command == 2'b01 && sp < 5) begin
            mem[sp] <= i_data;
            sp      <= sp + 1;
        end else if (command == 2'b10 && sp > 0) begin
            sp <= sp - 1;
        end
    end

    always_comb begin
        sel    = -1;
        o_data = 4'd0;
        if (command == 2'b10) sel = sp - 1;
        else if (command == 2'b11) sel = sp - 1 - int'(index);
        if (sel >= 0 && sel < 8) o_data = mem[sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One full request/response transaction; stall_cycles holds RSP_READY low after the response appears
    task automatic xact(input string tag, input logic [1:0] op, input logic [2:0] idx,
                        input logic [3:0] d, input logic exp_err, input logic [3:0] exp_data,
                        input int stall_cycles);
        logic [1:0] exp_cmd;
        logic [4:0] e;
        int         lat;
        bit         got;
        exp_cmd = (exp_err || op == 2'b00) ? 2'b00 : op;
        @(negedge clk);
        rsp_ready = (stall_cycles == 0);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_index = idx;
        req_data  = d;
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin
                got = 1;
                break;
            end
            check({tag, ".command"}, 32'(command), 32'(exp_cmd));
            check({tag, ".i_data"}, 32'(i_data), (exp_cmd == 2'b01) ? 32'(d) : 32'd0);
            check({tag, ".index"}, 32'(index), (exp_cmd == 2'b11) ? 32'(idx) : 32'd0);
            lat++;
            @(negedge clk);
        end
        check({tag, ".rsp_seen"}, 32'(got), 32'd1);
        if (!got) begin
            void'(exp_q.pop_front());
            return;
        end
        check({tag, ".latency"}, 32'(lat), (exp_cmd != 2'b00) ? 32'd2 : 32'd1);
        check({tag, ".cmd_in_resp"}, 32'(command), 32'd0);
        e = exp_q.pop_front();
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'(e[4]));
        check({tag, ".rsp_data"}, 32'(rsp_data), 32'(e[3:0]));
        for (int s = 0; s < stall_cycles; s++) begin
            @(negedge clk);
            check({tag, ".stall_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".stall_data"}, 32'(rsp_data), 32'(e[3:0]));
            check({tag, ".stall_err"}, 32'(rsp_err), 32'(e[4]));
            check({tag, ".stall_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, ".rsp_dropped"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit stale;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_index = 3'd0;
        req_data  = 4'd0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.count", 32'(count), 32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full", 32'(full), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_data", 32'(rsp_data), 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.command", 32'(command), 32'd0);
        rst_n = 1'b1;

        xact("push3", 2'b01, 3'd0, 4'd3, 1'b0, 4'd0, 0);
        xact("push7", 2'b01, 3'd0, 4'd7, 1'b0, 4'd0, 0);
        xact("push9", 2'b01, 3'd0, 4'd9, 1'b0, 4'd0, 0);
        check("count_after_3push", 32'(count), 32'd3);

        xact("get0", 2'b11, 3'd0, 4'd0, 1'b0, 4'd9, 0);
        xact("get2", 2'b11, 3'd2, 4'd0, 1'b0, 4'd3, 0);
        xact("pop9", 2'b10, 3'd0, 4'd0, 1'b0, 4'd9, 0);
        check("count_after_pop", 32'(count), 32'd2);

        xact("get2_oob", 2'b11, 3'd2, 4'd0, 1'b1, 4'd0, 0);
        xact("nop", 2'b00, 3'd5, 4'd15, 1'b0, 4'd0, 0);

        xact("push1", 2'b01, 3'd0, 4'd1, 1'b0, 4'd0, 0);
        xact("push2", 2'b01, 3'd0, 4'd2, 1'b0, 4'd0, 0);
        xact("push4", 2'b01, 3'd0, 4'd4, 1'b0, 4'd0, 0);
        check("count_full", 32'(count), 32'd5);
        check("full_flag", 32'(full), 32'd1);
        xact("push_over", 2'b01, 3'd0, 4'd8, 1'b1, 4'd0, 0);
        check("count_still_full", 32'(count), 32'd5);
        xact("get4", 2'b11, 3'd4, 4'd0, 1'b0, 4'd3, 0);
        xact("get5_oob", 2'b11, 3'd5, 4'd0, 1'b1, 4'd0, 0);

        xact("pop4_stall", 2'b10, 3'd0, 4'd0, 1'b0, 4'd4, 4);
        xact("pop2", 2'b10, 3'd0, 4'd0, 1'b0, 4'd2, 0);
        xact("pop1", 2'b10, 3'd0, 4'd0, 1'b0, 4'd1, 0);
        xact("pop7", 2'b10, 3'd0, 4'd0, 1'b0, 4'd7, 0);
        xact("pop3", 2'b10, 3'd0, 4'd0, 1'b0, 4'd3, 0);
        check("empty_flag", 32'(empty), 32'd1);
        xact("pop_empty", 2'b10, 3'd0, 4'd0, 1'b1, 4'd0, 0);
        xact("get_empty", 2'b11, 3'd0, 4'd0, 1'b1, 4'd0, 0);
        check("still_empty", 32'(empty), 32'd1);

        // Asynchronous reset while a push is in ISSUE
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 4'd11;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        check("mid.command_issue", 32'(command), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.command_rst", 32'(command), 32'd0);
        check("mid.rsp_valid_rst", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1;
        end
        check("mid.no_stale_rsp", 32'(stale), 32'd0);
        check("mid.count", 32'(count), 32'd0);
        check("mid.req_ready", 32'(req_ready), 32'd1);

        xact("push6_after_rst", 2'b01, 3'd0, 4'd6, 1'b0, 4'd0, 0);
        xact("get0_after_rst", 2'b11, 3'd0, 4'd0, 1'b0, 4'd6, 0);
        check("count_after_rst", 32'(count), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
